display_scan_ctrl: RTL
======================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter SHOW_CYCLES, default 1000: number of clk_scan cycles one digit anode stays lit per slot; legal range 1..65535.
REQ-002 Parameter BLANK_CYCLES, default 2: number of anti-ghosting cycles with all anodes off after each sel_out change; legal range 1..255.
REQ-003 Port clk_scan, input, 1: single clock; all logic is on the rising edge.
REQ-004 Port rst_scan, input, 1: reset, synchronous and active-high.
REQ-005 Port enable_in, input, 1: scanning runs while 1.
REQ-006 Port skip_null_in, input, 1: when 1, the NULL slot is omitted from the frame.
REQ-007 Port sel_out, output, 2: digit select code driven to the digit mux (01 = sec, 10 = ten-sec, 11 = min, 00 = null).
REQ-008 Port anode_out, output, 4: active-low one-hot digit enable; bit0 = sec, bit1 = ten-sec, bit2 = min, bit3 = null position; 1111 means all off.
REQ-009 Port frame_done_out, output, 1: one-cycle pulse at the end of every completed frame.

Function
REQ-010 The FSM SHALL have three states: IDLE, BLANK and SHOW.
REQ-011 IDLE: sel_out = 00 and anode_out = 1111; when enable_in = 1, the next state SHALL be BLANK with slot 0 selected.
REQ-012 Slot order SHALL be 0 (sel 01, anode bit0), 1 (sel 10, bit1), 2 (sel 11, bit2), 3 (sel 00, bit3).
REQ-013 sel_out SHALL take the slot code on the same edge the FSM enters BLANK and SHALL hold it through the following SHOW.
REQ-014 BLANK SHALL last exactly BLANK_CYCLES cycles with anode_out = 1111; this covers the one-cycle registered latency of the digit mux.
REQ-015 SHOW SHALL last exactly SHOW_CYCLES cycles with only the current slot's anode bit driven to 0.
REQ-016 After SHOW, the FSM SHALL advance to BLANK of the next slot; after slot 3, or after slot 2 when the frame runs 3 slots, it SHALL wrap to slot 0.
REQ-017 skip_null_in SHALL be sampled only when slot 0 is entered and SHALL hold for the whole frame; a mid-frame change SHALL take effect in the next frame.
REQ-018 Frame period SHALL be 4*(BLANK_CYCLES+SHOW_CYCLES) cycles, or 3*(BLANK_CYCLES+SHOW_CYCLES) when the NULL slot is skipped.
REQ-019 frame_done_out SHALL be high for exactly one cycle: the last SHOW cycle of the frame's last slot.
REQ-020 If enable_in = 0 in any state, the next cycle SHALL be IDLE with anodes off, sel_out = 00 and counters cleared, and no frame_done_out pulse SHALL occur; the next enable restarts at slot 0.
REQ-021 The slot timer SHALL be a 16-bit down-counter loaded with the duration minus 1; a state transition SHALL occur when it reaches 0.
REQ-022 Two anode bits SHALL never be low in the same cycle, and an anode bit SHALL never be low in the first cycle after a sel_out change.

Reset
REQ-023 While rst_scan = 1 at a clock edge: state = IDLE, slot = 0, counter = 0, sel_out = 00, anode_out = 1111, frame_done_out = 0, and the latched skip flag = 0.
REQ-024 Reset SHALL override enable_in and SHALL abort any slot in progress; scanning resumes at slot 0 BLANK in the first cycle after rst_scan = 0 with enable_in = 1.
REQ-025 All outputs SHALL be registered.

Structure
REQ-026 The shared package scoreboard_pkg SHALL hold the SEL_SEC/SEL_TEN_SEC/SEL_MIN/SEL_NULL codes, the ANODE_OFF = 1111 constant and the scan state enum.
REQ-027 One sub-module, scan_slot_timer (a loadable 16-bit down-counter with a zero flag), SHALL be instantiated.

Verification (SHOW_CYCLES=4, BLANK_CYCLES=2)
REQ-028 Reset release with enable_in=1: sel_out=01 for 6 cycles (anode 1111 ×2, then 1110 ×4), then sel 10/1101, 11/1011, 00/0111; frame_done_out pulses every 24 cycles.
REQ-029 skip_null_in=1 before slot 0: sel sequence 01,10,11 repeats; frame_done_out period is 18 cycles; anode bit3 is never low.
REQ-030 skip_null_in toggled during slot 1: the current frame keeps its length, and the new frame length applies from the next slot 0.
REQ-031 enable_in dropped during SHOW of slot 2: next cycle anode_out=1111 and sel_out=00, with no frame_done_out pulse; on re-enable, sel_out=01 starts again.
REQ-032 rst_scan pulsed for 1 cycle mid-BLANK: outputs take reset values, and the 6-cycle slot 0 restarts.
REQ-033 A checker SHALL run on every cycle: anode_out has at most one 0 bit, and anode_out = 1111 in any cycle where sel_out changed on the previous edge.

Source files
------------

// File: rtl/scoreboard_pkg.sv
// Shared constants and types for the multiplexed display scanner: digit
// select codes, the all-off anode pattern and the scan FSM state type.
package scoreboard_pkg;

  localparam logic [1:0] SEL_SEC     = 2'b01;
  localparam logic [1:0] SEL_TEN_SEC = 2'b10;
  localparam logic [1:0] SEL_MIN     = 2'b11;
  localparam logic [1:0] SEL_NULL    = 2'b00;

  localparam logic [3:0] ANODE_OFF = 4'b1111;

  localparam int TIMER_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_e;

  function automatic logic [1:0] slot_sel(input logic [1:0] slot);
    logic [1:0] code;
    case (slot)
      2'd0:    code = SEL_SEC;
      2'd1:    code = SEL_TEN_SEC;
      2'd2:    code = SEL_MIN;
      default: code = SEL_NULL;
    endcase
    return code;
  endfunction

  // Active-low one-hot: only the slot's own anode bit is pulled to 0.
  function automatic logic [3:0] slot_anode(input logic [1:0] slot);
    return ~(4'b0001 << slot);
  endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Loadable down-counter that times the BLANK and SHOW intervals; it parks
// at zero rather than wrapping.
module scan_slot_timer
  import scoreboard_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               dec_i,
  output logic [TIMER_W-1:0] count_o,
  output logic               zero_o
);

  logic [TIMER_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - {{(TIMER_W-1){1'b0}}, 1'b1};
    end
  end

  assign count_o = cnt_q;
  assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 4-digit display scanner: cycles slots with a blanking
// gap after every select change so the registered digit mux can settle.
module display_scan_ctrl
  import scoreboard_pkg::*;
#(
  parameter int SHOW_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic       clk_scan,
  input  logic       rst_scan,
  input  logic       enable_in,
  input  logic       skip_null_in,
  output logic [1:0] sel_out,
  output logic [3:0] anode_out,
  output logic       frame_done_out
);

  localparam logic [TIMER_W-1:0] SHOW_LOAD  = TIMER_W'(SHOW_CYCLES - 1);
  localparam logic [TIMER_W-1:0] BLANK_LOAD = TIMER_W'(BLANK_CYCLES - 1);
  localparam logic               SHOW_ONE   = (SHOW_CYCLES == 1);

  scan_state_e state_q, state_d;
  logic [1:0]  slot_q, slot_d;
  logic        skip_q, skip_d;
  logic [1:0]  sel_q, sel_d;
  logic [3:0]  anode_q, anode_d;
  logic        done_q, done_d;

  logic               tmr_clr, tmr_load, tmr_dec, tmr_zero;
  logic [TIMER_W-1:0] tmr_load_val, tmr_count;

  logic       last_slot;
  logic [1:0] next_slot;

  scan_slot_timer u_timer (
    .clk_i      (clk_scan),
    .rst_i      (rst_scan),
    .clr_i      (tmr_clr),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .dec_i      (tmr_dec),
    .count_o    (tmr_count),
    .zero_o     (tmr_zero)
  );

  // The frame's closing slot depends on the skip flag latched at slot 0.
  assign last_slot = (slot_q == 2'd3) || ((slot_q == 2'd2) && skip_q);
  assign next_slot = last_slot ? 2'd0 : 2'(slot_q + 2'd1);

  always_ff @(posedge clk_scan) begin
    if (rst_scan) begin
      state_q <= ST_IDLE;
      slot_q  <= 2'd0;
      skip_q  <= 1'b0;
      sel_q   <= SEL_NULL;
      anode_q <= ANODE_OFF;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      skip_q  <= skip_d;
      sel_q   <= sel_d;
      anode_q <= anode_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    skip_d       = skip_q;
    sel_d        = sel_q;
    anode_d      = anode_q;
    done_d       = 1'b0;
    tmr_clr      = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = BLANK_LOAD;
    tmr_dec      = 1'b0;

    if (!enable_in) begin
      state_d = ST_IDLE;
      slot_d  = 2'd0;
      sel_d   = SEL_NULL;
      anode_d = ANODE_OFF;
      tmr_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d      = ST_BLANK;
          slot_d       = 2'd0;
          skip_d       = skip_null_in;
          sel_d        = slot_sel(2'd0);
          anode_d      = ANODE_OFF;
          tmr_load     = 1'b1;
          tmr_load_val = BLANK_LOAD;
        end
        ST_BLANK: begin
          anode_d = ANODE_OFF;
          if (tmr_zero) begin
            state_d      = ST_SHOW;
            anode_d      = slot_anode(slot_q);
            tmr_load     = 1'b1;
            tmr_load_val = SHOW_LOAD;
            // A one-cycle SHOW makes its only cycle the frame's final one.
            done_d       = last_slot && SHOW_ONE;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        ST_SHOW: begin
          if (tmr_zero) begin
            state_d      = ST_BLANK;
            slot_d       = next_slot;
            sel_d        = slot_sel(next_slot);
            anode_d      = ANODE_OFF;
            tmr_load     = 1'b1;
            tmr_load_val = BLANK_LOAD;
            if (last_slot) begin
              skip_d = skip_null_in;
            end
          end else begin
            tmr_dec = 1'b1;
            done_d  = last_slot && (tmr_count == TIMER_W'(1));
          end
        end
        default: begin
          state_d = ST_IDLE;
          slot_d  = 2'd0;
          sel_d   = SEL_NULL;
          anode_d = ANODE_OFF;
          tmr_clr = 1'b1;
        end
      endcase
    end
  end

  assign sel_out        = sel_q;
  assign anode_out      = anode_q;
  assign frame_done_out = done_q;

endmodule
